// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one of NUM_REQ requesters a shared 128-bit UART
// transmit path, with per-byte progress tracking and an inter-byte timeout abort.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned BYTES_PER_FRAME = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*128-1:0]   req_data,
  input  logic                     tx_byte_done,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic                     busy,
  output logic [127:0]             tx_data,
  output logic                     tx_en
);

  localparam int unsigned DATA_W = 128;
  localparam int unsigned PTR_W  = $clog2(NUM_REQ);
  localparam int unsigned CAND_W = PTR_W + 1;
  localparam int unsigned CNT_W  = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
  localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_FRAME - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SEND  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   winner;
  logic [CAND_W-1:0]  cand;
  logic               any_req;
  logic [CNT_W-1:0]   count;
  logic [TMO_W-1:0]   timeout;

  // Round-robin pick: scan from ptr+1 upward; descending loop lets the nearest index win.
  always_comb begin
    winner  = ptr;
    any_req = 1'b0;
    cand    = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      cand = CAND_W'(ptr) + CAND_W'(i);
      if (cand >= CAND_W'(NUM_REQ)) begin
        cand = cand - CAND_W'(NUM_REQ);
      end
      if (req[cand[PTR_W-1:0]]) begin
        winner  = cand[PTR_W-1:0];
        any_req = 1'b1;
      end
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SEND;
      S_SEND: begin
        if (tx_byte_done) begin
          if (count == CNT_LAST) state_nxt = S_DONE;
        end else if (timeout == TMO_LAST) begin
          state_nxt = S_ABORT;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ABORT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      ptr     <= PTR_W'(NUM_REQ - 1);
      owner   <= '0;
      count   <= '0;
      timeout <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      tx_en <= (state_nxt == S_SEND);
      done  <= '0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner <= winner;
            gnt   <= NUM_REQ'(1) << winner;
          end
        end
        S_LOAD: begin
          tx_data <= req_data[int'(owner)*DATA_W +: DATA_W];
          count   <= '0;
          timeout <= '0;
          ptr     <= owner;
        end
        S_SEND: begin
          // Counters saturate so they never wrap while a frame is in flight.
          if (tx_byte_done) begin
            timeout <= '0;
            if (count != CNT_LAST) count <= count + CNT_W'(1);
          end else if (timeout != TMO_LAST) begin
            timeout <= timeout + TMO_W'(1);
          end
          if (state_nxt == S_DONE)  done <= NUM_REQ'(1) << owner;
          if (state_nxt == S_ABORT) err  <= 1'b1;
        end
        default: gnt <= '0;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one 128-bit UART transmit path (legal 2..8).
REQ-002 Parameter BYTES_PER_FRAME, default 16, byte-done pulses that complete one 128-bit frame.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, maximum clk cycles allowed between consecutive byte-done pulses.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low; 0 forces reset state.
REQ-007 req  input  NUM_REQ  per-requester level request; holds until that requester's done or err.
REQ-008 req_data  input  NUM_REQ*128  flattened frames; requester i occupies bits [128*i+127:128*i].
REQ-009 gnt  output  NUM_REQ  one-hot owner indication, all-zero when idle.
REQ-010 done  output  NUM_REQ  one-cycle pulse to owner on frame completion.
REQ-011 err  output  1  one-cycle pulse on timeout abort.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 tx_data  output  128  latched frame to the transmit path's data input.
REQ-014 tx_en  output  1  enable to the transmit path.
REQ-015 tx_byte_done  input  1  one-cycle pulse per byte sent by the transmit path.

Function
REQ-016 FSM states IDLE, LOAD, SEND, DONE, ABORT; unused encodings SHALL return to IDLE.
REQ-017 IDLE: when any req bit is high, the block SHALL select the winner round-robin starting at index ptr+1 mod NUM_REQ, go to LOAD, and assert gnt for the winner from the next cycle.
REQ-018 LOAD (1 cycle): the block SHALL latch the winner's req_data slice into tx_data, clear byte count and timeout counter, set ptr to winner, then go to SEND.
REQ-019 SEND: tx_en SHALL be 1; each tx_byte_done pulse SHALL increment the byte count and clear the timeout counter.
REQ-020 SEND: when tx_byte_done arrives with count = BYTES_PER_FRAME-1, the block SHALL go to DONE.
REQ-021 DONE (1 cycle): tx_en=0, done[owner]=1, gnt stays on owner; next state IDLE with gnt cleared.
REQ-022 SEND: when the timeout counter reaches TIMEOUT_CYCLES-1 without tx_byte_done, the block SHALL go to ABORT.
REQ-023 ABORT (1 cycle): tx_en=0, err=1, done stays 0, gnt cleared next cycle; ptr still advances, so the aborted requester loses priority.
REQ-024 tx_data SHALL be stable from LOAD through DONE/ABORT; req_data changes after LOAD SHALL be ignored.
REQ-025 Dropping req[owner] during SEND SHALL NOT abort; the frame completes and done pulses.
REQ-026 tx_byte_done in IDLE, LOAD, DONE or ABORT SHALL be ignored and SHALL NOT affect count.
REQ-027 The minimum gap between frames is 1 IDLE cycle; back-to-back requests SHALL alternate fairly.
REQ-028 gnt, done and err SHALL always be one-hot or zero; done and err SHALL never be asserted together.
REQ-029 Counters SHALL be sized ceil(log2) of their limits; they SHALL NOT wrap inside SEND.

Reset
REQ-030 While reset=0: state=IDLE, gnt=0, done=0, err=0, busy=0, tx_en=0, tx_data=0, count=0, timeout=0, ptr=NUM_REQ-1 so requester 0 wins first.
REQ-031 Reset asserted mid-SEND SHALL drop tx_en within the same cycle (asynchronous) with no done or err pulse.

Verification
REQ-032 req=4'b0001, 16 tx_byte_done pulses 20 cycles apart -> gnt=0001, tx_data=slice0, tx_en high for SEND, done=0001 one cycle after the 16th pulse, busy low 2 cycles later.
REQ-033 req=4'b1111 held, each frame completed -> grant order 0,1,2,3,0; done pulses follow the same order.
REQ-034 req=4'b0100, 5 byte pulses, then none for 4096 cycles -> err one pulse, no done, tx_en low; next req=4'b0110 grants 1 before 2 (ptr was 2, so 3,0,1 are scanned first).
REQ-035 reset pulled low after 8 bytes of a frame from requester 3 -> all outputs zero immediately; after release req=4'b1000 -> requester 3 granted with a fresh count of 0.
REQ-036 req_data of the owner changed and req dropped mid-SEND -> tx_data unchanged, frame completes, done pulses.
REQ-037 Stray tx_byte_done in IDLE, then a full frame -> done after exactly 16 in-SEND pulses.
